// File: rtl/bus_err_drain.sv
// Reg-bus master that drains stored AXI bus errors (write unit / read unit) one at a time:
// read the oldest error, pop it, then emit it as a single record on a valid/ready stream.
module bus_err_drain #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned MetaWidth  = 2,
  parameter int unsigned ErrWidth   = 2,
  parameter logic [31:0] UnitOffset = 32'h20,
  parameter logic [31:0] OffCode    = 32'h00,
  parameter logic [31:0] OffAddrLo  = 32'h04,
  parameter logic [31:0] OffAddrHi  = 32'h08,
  parameter logic [31:0] OffMeta    = 32'h0C,
  parameter logic [31:0] OffPop     = 32'h10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [1:0]           err_irq_i,
  output logic [31:0]          reg_req_addr_o,
  output logic                 reg_req_write_o,
  output logic [31:0]          reg_req_wdata_o,
  output logic [3:0]           reg_req_wstrb_o,
  output logic                 reg_req_valid_o,
  input  logic [31:0]          reg_rsp_rdata_i,
  input  logic                 reg_rsp_error_i,
  input  logic                 reg_rsp_ready_i,
  output logic                 rec_valid_o,
  input  logic                 rec_ready_i,
  output logic                 rec_unit_o,
  output logic [AddrWidth-1:0] rec_addr_o,
  output logic [MetaWidth-1:0] rec_meta_o,
  output logic [ErrWidth-1:0]  rec_err_o,
  output logic                 bus_err_o,
  output logic [15:0]          drain_cnt_o
);
  localparam int unsigned LoW = (AddrWidth < 32) ? AddrWidth : 32;

  typedef enum logic [2:0] {
    IDLE, RD_CODE, RD_ALO, RD_AHI, RD_META, POP, EMIT, SETTLE
  } state_e;

  state_e               state_q, state_d;
  logic                 unit_q, unit_d;
  logic                 rr_q, rr_d;
  logic                 req_active;
  logic                 xfer_ok, xfer_err;
  logic [31:0]          off;
  logic [LoW-1:0]       addr_lo_q;
  logic [MetaWidth-1:0] meta_q;
  logic [ErrWidth-1:0]  err_q;

  // Request fields derive only from state and latched unit, so they hold until ready.
  assign req_active = (state_q == RD_CODE) || (state_q == RD_ALO) || (state_q == RD_AHI) ||
                      (state_q == RD_META) || (state_q == POP);
  assign xfer_ok    = req_active & reg_rsp_ready_i & ~reg_rsp_error_i;
  assign xfer_err   = req_active & reg_rsp_ready_i & reg_rsp_error_i;

  always_comb begin
    state_d         = state_q;
    unit_d          = unit_q;
    rr_d            = rr_q;
    off             = OffCode;
    reg_req_write_o = 1'b0;
    reg_req_wdata_o = 32'h0;
    reg_req_wstrb_o = 4'h0;
    unique case (state_q)
      IDLE: begin
        if (en_i && (|err_irq_i)) begin
          state_d = RD_CODE;
          if (&err_irq_i) begin
            unit_d = rr_q;
            rr_d   = ~rr_q;
          end else begin
            unit_d = err_irq_i[1];
          end
        end
      end
      RD_CODE: begin
        off = OffCode;
        if (xfer_ok) state_d = RD_ALO;
      end
      RD_ALO: begin
        off = OffAddrLo;
        if (xfer_ok) state_d = (AddrWidth > 32) ? RD_AHI : RD_META;
      end
      RD_AHI: begin
        off = OffAddrHi;
        if (xfer_ok) state_d = RD_META;
      end
      RD_META: begin
        off = OffMeta;
        if (xfer_ok) state_d = POP;
      end
      POP: begin
        off             = OffPop;
        reg_req_write_o = 1'b1;
        reg_req_wdata_o = 32'h1;
        reg_req_wstrb_o = 4'hF;
        if (xfer_ok) state_d = EMIT;
      end
      EMIT:    if (rec_ready_i) state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A failed access abandons the drain; the entry stays stored and is retried later.
    if (xfer_err) state_d = SETTLE;
    reg_req_valid_o = req_active;
    reg_req_addr_o  = req_active ? ((unit_q ? UnitOffset : 32'h0) + off) : 32'h0;
  end

  assign rec_valid_o = (state_q == EMIT);
  assign rec_unit_o  = unit_q;
  assign rec_meta_o  = meta_q;
  assign rec_err_o   = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      unit_q      <= 1'b0;
      rr_q        <= 1'b0;
      bus_err_o   <= 1'b0;
      drain_cnt_o <= 16'h0;
      addr_lo_q   <= '0;
      meta_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      rr_q    <= rr_d;
      if (xfer_err) bus_err_o <= 1'b1;
      if (xfer_ok) begin
        case (state_q)
          RD_CODE: err_q     <= reg_rsp_rdata_i[ErrWidth-1:0];
          RD_ALO:  addr_lo_q <= reg_rsp_rdata_i[LoW-1:0];
          RD_META: meta_q    <= reg_rsp_rdata_i[MetaWidth-1:0];
          default: ;
        endcase
      end
      if (rec_valid_o && rec_ready_i && (drain_cnt_o != 16'hFFFF))
        drain_cnt_o <= drain_cnt_o + 16'h1;
    end
  end

  // Upper address word exists only for wide addresses.
  if (AddrWidth > 32) begin : g_addr_hi
    logic [AddrWidth-33:0] addr_hi_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        addr_hi_q <= '0;
      end else if (xfer_ok && (state_q == RD_AHI)) begin
        addr_hi_q <= reg_rsp_rdata_i[AddrWidth-33:0];
      end
    end
    assign rec_addr_o = {addr_hi_q, addr_lo_q};
  end else begin : g_addr_lo
    assign rec_addr_o = addr_lo_q;
  end

endmodule

// File: tb/tb_bus_err_drain.sv
// Bench for bus_err_drain: a queue-based model of the two error units answers the reg bus,
// and the expected record stream is derived from the queue contents and the arbitration rule.
`timescale 1ns/1ps
module tb_bus_err_drain;
  typedef struct packed { logic [1:0] code; logic [31:0] addr; logic [1:0] meta; } ent_t;
  typedef struct packed { logic unit; logic [1:0] code; logic [31:0] addr; logic [1:0] meta; } rec_t;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  // 32-bit address instance
  logic        rst_n, en, rec_ready;
  logic [1:0]  irq;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_wstrb;
  logic        req_write, req_valid, rsp_error, rsp_ready;
  logic        rec_valid, rec_unit, bus_err;
  logic [31:0] rec_addr;
  logic [1:0]  rec_meta, rec_err;
  logic [15:0] drain_cnt;

  // 64-bit address instance
  logic        b_rst_n, b_en, b_rec_ready;
  logic [1:0]  b_irq;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_wstrb;
  logic        b_req_write, b_req_valid, b_rsp_error, b_rsp_ready;
  logic        b_rec_valid, b_rec_unit, b_bus_err;
  logic [63:0] b_rec_addr;
  logic [1:0]  b_rec_meta, b_rec_err;
  logic [15:0] b_drain_cnt;

  bus_err_drain #(.AddrWidth(32)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .err_irq_i(irq),
    .reg_req_addr_o(req_addr), .reg_req_write_o(req_write), .reg_req_wdata_o(req_wdata),
    .reg_req_wstrb_o(req_wstrb), .reg_req_valid_o(req_valid),
    .reg_rsp_rdata_i(rsp_rdata), .reg_rsp_error_i(rsp_error), .reg_rsp_ready_i(rsp_ready),
    .rec_valid_o(rec_valid), .rec_ready_i(rec_ready), .rec_unit_o(rec_unit),
    .rec_addr_o(rec_addr), .rec_meta_o(rec_meta), .rec_err_o(rec_err),
    .bus_err_o(bus_err), .drain_cnt_o(drain_cnt)
  );

  bus_err_drain #(.AddrWidth(64)) u_dut64 (
    .clk_i(clk), .rst_ni(b_rst_n), .en_i(b_en), .err_irq_i(b_irq),
    .reg_req_addr_o(b_req_addr), .reg_req_write_o(b_req_write), .reg_req_wdata_o(b_req_wdata),
    .reg_req_wstrb_o(b_req_wstrb), .reg_req_valid_o(b_req_valid),
    .reg_rsp_rdata_i(b_rsp_rdata), .reg_rsp_error_i(b_rsp_error), .reg_rsp_ready_i(b_rsp_ready),
    .rec_valid_o(b_rec_valid), .rec_ready_i(b_rec_ready), .rec_unit_o(b_rec_unit),
    .rec_addr_o(b_rec_addr), .rec_meta_o(b_rec_meta), .rec_err_o(b_rec_err),
    .bus_err_o(b_bus_err), .drain_cnt_o(b_drain_cnt)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-unit error stores, arbitration pointer, expected records.
  ent_t fifo0[$];
  ent_t fifo1[$];
  rec_t exp_q[$];
  bit   m_rr = 1'b0;
  int   m_cnt = 0;
  int   dly_min = 0, dly_max = 0, bp_pct = 100, bp_hold = 0, err_off = -1;
  logic [31:0] b_log[$];

  function automatic ent_t rnd_ent();
    ent_t e;
    e.code = 2'($urandom_range(0, 3));
    e.addr = $urandom;
    e.meta = 2'($urandom_range(0, 3));
    return e;
  endfunction

  task automatic predict();
    ent_t c0[$];
    ent_t c1[$];
    ent_t e;
    rec_t r;
    bit   u;
    c0 = fifo0;
    c1 = fifo1;
    while (c0.size() > 0 || c1.size() > 0) begin
      if (c0.size() > 0 && c1.size() > 0) begin
        u    = m_rr;
        m_rr = ~m_rr;
      end else begin
        u = (c1.size() > 0);
      end
      e = u ? c1.pop_front() : c0.pop_front();
      r.unit = u; r.code = e.code; r.addr = e.addr; r.meta = e.meta;
      exp_q.push_back(r);
    end
  endtask

  task automatic wait_drained(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done"}, exp_q.size(), 0);
    repeat (4) @(negedge clk);
    check_eq({tag, "_cnt"}, drain_cnt, m_cnt);
  endtask

  // Error-unit responder: serves reads from the head of the addressed store, pops on POP.
  initial begin : slave_a
    logic        busy;
    int          wait_left, idx;
    logic [69:0] snap;
    logic [4:0]  off;
    logic        exp_unit;
    ent_t        h;
    logic [31:0] exp_offs [4];
    exp_offs  = '{32'h0, 32'h4, 32'hC, 32'h10};
    busy      = 1'b0;
    wait_left = 0;
    idx       = 0;
    snap      = '0;
    rsp_ready = 1'b0; rsp_error = 1'b0; rsp_rdata = 32'h0; irq = 2'b00;
    forever begin
      @(negedge clk);
      if (rsp_ready) begin
        if (rsp_error) begin
          idx = 0;
        end else if (snap[69:38] % 32'h20 == 32'h10) begin
          if (snap[69:38] >= 32'h20) begin
            if (fifo1.size() > 0) void'(fifo1.pop_front());
          end else begin
            if (fifo0.size() > 0) void'(fifo0.pop_front());
          end
          idx = 0;
        end else begin
          idx++;
        end
        busy = 1'b0; rsp_ready = 1'b0; rsp_error = 1'b0;
      end
      if (rec_valid) check_eq("no_reg_traffic_in_emit", req_valid, 0);
      if (busy) check_eq("req_stable", {req_addr, req_wdata, req_wstrb, req_write, req_valid}, snap);
      if (req_valid && !busy) begin
        busy      = 1'b1;
        snap      = {req_addr, req_wdata, req_wstrb, req_write, req_valid};
        wait_left = $urandom_range(dly_max, dly_min);
        exp_unit  = (exp_q.size() > 0) ? exp_q[0].unit : 1'b0;
        check_eq("req_addr", req_addr,
                 (exp_unit ? 32'h20 : 32'h0) + ((idx < 4) ? exp_offs[idx] : 32'hFF));
        check_eq("req_write", req_write, (idx == 3));
        if (idx == 3) check_eq("pop_wdata_wstrb", {req_wdata, req_wstrb}, {32'h1, 4'hF});
      end
      if (busy && !rsp_ready) begin
        if (wait_left == 0) begin
          off = req_addr[4:0];
          h   = '0;
          if (req_addr >= 32'h20) begin
            if (fifo1.size() > 0) h = fifo1[0];
          end else begin
            if (fifo0.size() > 0) h = fifo0[0];
          end
          rsp_ready = 1'b1;
          rsp_error = (err_off == int'(off));
          if (rsp_error) err_off = -1;
          case (off)
            5'h00:   rsp_rdata = {30'($urandom), h.code};
            5'h04:   rsp_rdata = h.addr;
            5'h0C:   rsp_rdata = {30'($urandom), h.meta};
            default: rsp_rdata = $urandom;
          endcase
        end else begin
          wait_left--;
        end
      end
      irq = {fifo1.size() != 0, fifo0.size() != 0};
    end
  end

  // Record sink with configurable backpressure; every valid cycle is checked against the model.
  initial begin : sink_a
    rec_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rec_valid) begin
        if (bp_hold > 0) begin
          rec_ready = 1'b0;
          bp_hold--;
        end else begin
          rec_ready = ($urandom_range(1, 100) <= bp_pct);
        end
        if (exp_q.size() == 0) begin
          check_eq("unexpected_rec", 1, 0);
        end else begin
          check_eq("rec", {rec_unit, rec_err, rec_addr, rec_meta}, exp_q[0]);
          if (rec_ready) begin
            void'(exp_q.pop_front());
            m_cnt++;
          end
        end
      end else begin
        rec_ready = ($urandom_range(1, 100) <= bp_pct);
      end
    end
  end

  // Wide-address responder: always ready, fixed register contents.
  initial begin : slave_b
    b_rsp_ready = 1'b0; b_rsp_error = 1'b0; b_rsp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      b_rsp_ready = b_req_valid;
      if (b_req_valid) begin
        b_log.push_back(b_req_addr);
        case (b_req_addr)
          32'h00:  b_rsp_rdata = 32'h1;
          32'h04:  b_rsp_rdata = 32'h4;
          32'h08:  b_rsp_rdata = 32'h1;
          32'h0C:  b_rsp_rdata = 32'h2;
          default: b_rsp_rdata = 32'h0;
        endcase
      end
    end
  end

  initial begin : main
    int n;
    logic [31:0] exp_b [5];
    exp_b = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    rst_n = 1'b0; en = 1'b0;
    b_rst_n = 1'b0; b_en = 1'b1; b_irq = 2'b00; b_rec_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_req_valid", req_valid, 0);
    check_eq("rst_rec_valid", rec_valid, 0);
    check_eq("rst_outputs", {bus_err, drain_cnt, rec_addr, rec_unit, rec_meta, rec_err}, 0);
    rst_n = 1'b1; b_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write-unit error, no wait states
    fifo0.push_back('{code: 2'd2, addr: 32'h8000_1000, meta: 2'd3});
    predict();
    en = 1'b1;
    wait_drained("single");

    // Both IRQs held: alternate between units
    for (int i = 0; i < 2; i++) begin
      fifo0.push_back(rnd_ent());
      fifo1.push_back(rnd_ent());
    end
    predict();
    wait_drained("round_robin");

    // Slow reg bus
    dly_min = 3; dly_max = 3;
    fifo0.push_back('{code: 2'd2, addr: 32'h8000_1000, meta: 2'd3});
    predict();
    wait_drained("slow_bus");
    dly_min = 0; dly_max = 0;

    // Error on the address read abandons the drain; the entry is retried
    check_eq("bus_err_clear", bus_err, 0);
    err_off = 4;
    fifo0.push_back(rnd_ent());
    predict();
    wait_drained("bus_error");
    check_eq("bus_err_sticky", bus_err, 1);

    // Record backpressure
    bp_hold = 10;
    fifo1.push_back(rnd_ent());
    predict();
    wait_drained("backpressure");

    // Enable dropped mid-drain: current drain finishes, next one is held off
    fifo0.push_back(rnd_ent());
    fifo0.push_back(rnd_ent());
    predict();
    n = 0;
    while (!req_valid && n < 50) begin @(negedge clk); n++; end
    en = 1'b0;
    n = 0;
    while (exp_q.size() > 1 && n < 200) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    check_eq("en_block_pending", exp_q.size(), 1);
    check_eq("en_block_idle", req_valid, 0);
    en = 1'b1;
    wait_drained("en_resume");

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      dly_max = $urandom_range(0, 3);
      bp_pct  = $urandom_range(30, 100);
      for (int k = $urandom_range(0, 3); k > 0; k--) fifo0.push_back(rnd_ent());
      for (int k = $urandom_range(0, 3); k > 0; k--) fifo1.push_back(rnd_ent());
      predict();
      wait_drained("random");
    end
    check_eq("bus_err_final", bus_err, 1);

    // Wide address: extra high-word read
    b_irq = 2'b01;
    n = 0;
    while (!b_rec_valid && n < 200) begin @(negedge clk); n++; end
    b_irq = 2'b00;
    check_eq("b_rec_valid", b_rec_valid, 1);
    check_eq("b_rec", {b_rec_unit, b_rec_err, b_rec_addr, b_rec_meta},
             {1'b0, 2'd1, 64'h1_0000_0004, 2'd2});
    check_eq("b_access_count", b_log.size(), 5);
    for (int i = 0; i < 5; i++)
      check_eq("b_access_addr", (i < b_log.size()) ? b_log[i] : 32'hFFFF_FFFF, exp_b[i]);
    repeat (3) @(negedge clk);
    check_eq("b_drain_cnt", b_drain_cnt, 1);

    // Asynchronous reset in the middle of a drain
    b_irq = 2'b01;
    n = 0;
    while (!(b_req_valid && b_req_addr == 32'hC) && n < 200) begin @(negedge clk); n++; end
    check_eq("b_reached_meta", b_req_addr, 32'hC);
    #1 b_rst_n = 1'b0;
    #1;
    check_eq("b_rst_req_valid", b_req_valid, 0);
    check_eq("b_rst_outputs",
             {b_rec_valid, b_bus_err, b_drain_cnt, b_rec_addr, b_rec_unit, b_rec_meta, b_rec_err}, 0);
    b_irq = 2'b00;
    @(negedge clk);
    b_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
